ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, is the instruction queue depth; legal values are powers of two, 2..16.
REQ-003 clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 redirect, input, 1 bit: a taken branch or jump; restarts fetch at redirect_pc.
REQ-006 redirect_pc, input, 32 bits: the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 mem_req_valid, output, 1 bit: a fetch request is offered this cycle.
REQ-008 mem_req_addr, output, 32 bits: the word-aligned fetch address.
REQ-009 mem_req_ready, input, 1 bit: instruction memory accepts the request this cycle.
REQ-010 mem_resp_valid, input, 1 bit: returns one instruction word; responses arrive in request order, no earlier than 1 cycle after acceptance, and cannot be stalled.
REQ-011 mem_resp_data, input, 32 bits: the instruction word.
REQ-012 inst_valid, output, 1 bit: the queue head is valid for decode.
REQ-013 inst, output, 32 bits: the head instruction.
REQ-014 inst_pc, output, 32 bits: the address of the head instruction.
REQ-015 inst_ready, input, 1 bit: decode consumes the head; a pop occurs when inst_valid && inst_ready.

Function
REQ-016 The block holds fetch_pc, a DEPTH-entry circular queue of {pc, inst}, an outstanding counter, and a stale counter.
REQ-017 A request is accepted when mem_req_valid && mem_req_ready; on acceptance, fetch_pc advances by 4, wrapping modulo 2^32.
REQ-018 The FSM has two states, FETCH and DRAIN; reset enters FETCH.
REQ-019 In FETCH, mem_req_valid = !redirect && (queue_count + outstanding < DEPTH), so the queue can never overflow.
REQ-020 In DRAIN, mem_req_valid = 0.
REQ-021 mem_req_addr = fetch_pc at all times.
REQ-022 In FETCH, each response that is not stale is written to the tail as {pc of its request, mem_resp_data}, and outstanding decrements.
REQ-023 The request pc is tracked by a DEPTH-entry pc FIFO, or by an equivalent derivation from the head pc plus the in-flight count.
REQ-024 inst_valid = (queue_count != 0), and inst/inst_pc are driven from registered head storage.
REQ-025 A response written in cycle N is visible at the head no earlier than cycle N+1.
REQ-026 When the queue is empty and a response arrives, the data is not forwarded combinationally.
REQ-027 A simultaneous push and pop on a full or empty queue is legal, and queue_count is unchanged.
REQ-028 On redirect in any state, the queue is flushed (count = 0), inst_valid = 0 in the next cycle, and fetch_pc is set to redirect_pc.
REQ-029 On redirect, stale = outstanding minus any response arriving that same cycle, and outstanding = 0.
REQ-030 On redirect, the next state is DRAIN if the new stale value is > 0, otherwise FETCH.
REQ-031 In DRAIN, each mem_resp_valid decrements stale and its data is discarded; when stale reaches 0, the next state is FETCH.
REQ-032 A redirect while in DRAIN adds the current outstanding to stale; this value is 0 because no requests are issued in DRAIN.
REQ-033 Redirect takes priority over a pop in the same cycle.
REQ-034 A pop with no redirect in the same cycle as an accepted request is legal; credit is computed on pre-edge counts.

Reset
REQ-035 On reset: fetch_pc = RESET_PC, the queue is empty, outstanding = 0, stale = 0, and state = FETCH.
REQ-036 While reset is asserted, mem_req_valid = 0 and inst_valid = 0; inst and inst_pc are 0.
REQ-037 Responses arriving during reset, or after reset mid-operation, are ignored, and memory is required to be reset together with this block.

Structure
REQ-038 Package ifetch_pkg holds the FSM state enum (FETCH, DRAIN), the 32-bit address typedef, and the constant INST_NOP = 32'h0000_0013.
REQ-039 A single sub-module, sync_fifo (parameter DEPTH, WIDTH=64), implements the circular queue with full and empty outputs; the FSM and counters live in ifetch_queue.

Verification
REQ-040 Reset release, mem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; inst_pc=0x0 with inst_valid first seen 2 cycles after the first acceptance.
REQ-041 inst_ready=0 held, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0; raising inst_ready pops 0x0..0xC in order and fetch resumes at 0x10.
REQ-042 Redirect to 0x100 with 2 requests outstanding -> state DRAIN; the next 2 responses are dropped; the first request is 0x100 after the drain; the first popped inst_pc is 0x100.
REQ-043 Redirect to 0x200 in the same cycle as a response, with 1 outstanding -> stale=0, no DRAIN, and a request to 0x200 in the next cycle.
REQ-044 Random mem_req_ready and response latency of 1-5 cycles, 1000 instructions -> every popped {inst_pc, inst} matches the memory model; no overflow; queue_count + outstanding <= DEPTH always.
REQ-045 Reset asserted mid-DRAIN -> the next cycle after release shows mem_req_addr=RESET_PC, inst_valid=0, and stale=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch queue.
//   addr_t        - 32-bit byte address
//   fetch_state_e - fetch FSM states (FETCH issues requests, DRAIN discards
//                   responses to requests made before a redirect)
//   iq_entry_t    - one queue entry {pc, inst}
//   INST_NOP      - canonical RV32I nop encoding (addi x0, x0, 0)
package ifetch_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    addr_t       pc;
    logic [31:0] inst;
  } iq_entry_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// sync_fifo: DEPTH-entry circular queue with registered storage.
//   clk, reset     - clock, synchronous active-high reset (empties the queue)
//   flush          - empties the queue this edge; wins over push/pop
//   push/push_data - write one entry at the tail
//   pop            - retire the head entry
//   head_data      - head entry, read straight from the storage registers
//   count          - number of valid entries (0..DEPTH)
//   full/empty     - status flags
// A push into an empty queue is only visible at head_data after the edge,
// so there is never a combinational path from push_data to head_data.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so push while full is fine with a pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: sequential state is assigned with <= so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/empty mark which slots are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetcher feeding a DEPTH-entry queue.
//   clk, reset                  - clock, synchronous active-high reset
//   redirect, redirect_pc       - restart fetch at redirect_pc (word aligned)
//   mem_req_valid/addr/ready    - fetch request handshake to instruction memory
//   mem_resp_valid/data         - in-order, unstallable instruction responses
//   inst_valid/inst/inst_pc     - queue head towards decode
//   inst_ready                  - decode consumes the head
// Requests are only issued while queue entries plus in-flight requests leave
// room, so every response has a guaranteed slot. After a redirect, responses
// to older requests are counted off in DRAIN and discarded.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  addr_t         fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] stale_q, stale_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  iq_entry_t     head, push_entry;
  logic          accept, resp_live, push, pop;
  logic [CW:0]   in_use, drain_total;
  addr_t         resp_pc;

  assign in_use        = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign mem_req_valid = !reset && (state_q == FETCH) && !redirect &&
                         (in_use < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign accept        = mem_req_valid && mem_req_ready;

  // In FETCH all outstanding requests are consecutive words ending just below
  // fetch_pc, so the oldest one (the one responding) is fetch_pc - 4*outstanding.
  assign resp_live  = mem_resp_valid && !reset && (state_q == FETCH);
  assign resp_pc    = fetch_pc_q - (addr_t'(outstanding_q) << 2);
  assign push_entry = '{pc: resp_pc, inst: mem_resp_data};

  // Redirect flushes the queue, so it overrides both the push and the pop.
  assign push = resp_live && !redirect && (!fifo_full || pop);
  assign pop  = inst_valid && inst_ready && !redirect;

  assign inst_valid = !reset && !fifo_empty;
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    drain_total   = {1'b0, stale_q} + {1'b0, outstanding_q};

    if (redirect) begin
      fetch_pc_d    = redirect_pc & ~32'h3;
      outstanding_d = '0;
      // A response arriving this cycle belongs to an old request and is
      // already accounted for, so it does not need draining.
      if (mem_resp_valid && (drain_total != '0)) drain_total = drain_total - (CW+1)'(1);
      stale_d = drain_total[CW-1:0];
      state_d = (drain_total != '0) ? DRAIN : FETCH;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp_live);
      if (state_q == DRAIN) begin
        if (mem_resp_valid && (stale_q != '0)) stale_d = stale_q - CW'(1);
        if (stale_d == '0) state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random checks of ifetch_queue against a
// simple in-order memory model with configurable response latency.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect, mem_req_ready, mem_resp_valid, inst_ready;
  logic [31:0] redirect_pc, mem_resp_data;
  logic        mem_req_valid, inst_valid;
  logic [31:0] mem_req_addr, inst, inst_pc;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_inst_log[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          acc_cnt = 0;

  // One clock cycle: sample handshakes before the edge, update the memory
  // model after it, then present this cycle's response.
  task automatic cycle();
    logic        acc, popped, resp_now;
    logic [31:0] acc_addr, p_pc, p_inst;
    #1;
    acc      = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    popped   = inst_valid && inst_ready;
    p_pc     = inst_pc;
    p_inst   = inst;
    resp_now = mem_resp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      pend.delete();
    end else begin
      if (resp_now && pend.size() > 0) void'(pend.pop_front());
      if (acc) begin
        pend.push_back('{addr: acc_addr,
                         due: cyc - 1 + int'($urandom_range(lat_max, lat_min))});
        acc_log.push_back(acc_addr);
        acc_cnt++;
      end
      if (popped) begin
        pop_pc_log.push_back(p_pc);
        pop_inst_log.push_back(p_inst);
      end
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(pend[0].addr);
    end
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_req_ready = 1'b0;
    inst_ready    = 1'b0;
    #1;
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    check("rst_rel_addr", mem_req_addr, RESET_PC);
    check("rst_rel_inst_valid", inst_valid, 1'b0);
    acc_log.delete();
    pop_pc_log.delete();
    pop_inst_log.delete();
    acc_cnt = 0;
  endtask

  // Two requests in flight with 3-cycle latency, then redirect to target.
  task automatic setup_drain(input logic [31:0] target);
    lat_min = 3; lat_max = 3;
    inst_ready    = 1'b1;
    mem_req_ready = 1'b1;
    cycle();
    cycle();
    mem_req_ready = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = target;
    #1;
    check("drain_req_suppressed", mem_req_valid, 1'b0);
    cycle();
    redirect = 1'b0;
    #1;
  endtask

  initial begin
    int          n;
    logic [31:0] exp_pc;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;

    // Back-to-back fetch with a 1-cycle memory.
    do_reset();
    lat_min = 1; lat_max = 1;
    mem_req_ready = 1'b1; inst_ready = 1'b1;
    #1;
    check("t40_req0_valid", mem_req_valid, 1'b1);
    check("t40_req0_addr", mem_req_addr, 32'h0);
    cycle();
    check("t40_req1_addr", mem_req_addr, 32'h4);
    check("t40_no_forward", inst_valid, 1'b0);
    cycle();
    check("t40_req2_addr", mem_req_addr, 32'h8);
    check("t40_head_valid", inst_valid, 1'b1);
    check("t40_head_pc", inst_pc, 32'h0);
    check("t40_head_inst", inst, mem_word(32'h0));

    // Decode stalled: credit limits to DEPTH requests, then drain in order.
    do_reset();
    mem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (8) cycle();
    check("t41_acc_cnt", acc_cnt, DEPTH);
    check("t41_req_stopped", mem_req_valid, 1'b0);
    check("t41_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    acc_log.delete();
    repeat (6) cycle();
    check("t41_pop_cnt", pop_pc_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < pop_pc_log.size(); i++) begin
      check("t41_pop_pc", pop_pc_log[i], 32'(i * 4));
      check("t41_pop_inst", pop_inst_log[i], mem_word(32'(i * 4)));
    end
    check("t41_resume_seen", acc_log.size() > 0, 1'b1);
    if (acc_log.size() > 0) check("t41_resume_addr", acc_log[0], 32'h10);

    // Redirect with two requests outstanding: DRAIN drops both responses.
    do_reset();
    setup_drain(32'h0000_0103);
    check("t42_state", 32'(dut.state_q), 32'(DRAIN));
    check("t42_stale", 32'(dut.stale_q), 32'd2);
    check("t42_inst_valid", inst_valid, 1'b0);
    check("t42_addr", mem_req_addr, 32'h100);
    mem_req_ready = 1'b1;
    acc_log.delete(); pop_pc_log.delete(); pop_inst_log.delete();
    n = 0;
    while (pop_pc_log.size() == 0 && n < 30) begin cycle(); n++; end
    check("t42_pop_timeout", n < 30, 1'b1);
    if (pop_pc_log.size() > 0) begin
      check("t42_first_pop_pc", pop_pc_log[0], 32'h100);
      check("t42_first_pop_inst", pop_inst_log[0], mem_word(32'h100));
    end
    if (acc_log.size() > 0) check("t42_first_req", acc_log[0], 32'h100);

    // Redirect coinciding with the only outstanding response: no DRAIN.
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle();
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    check("t43_outstanding", 32'(dut.outstanding_q), 32'd1);
    cycle();
    redirect = 1'b0;
    #1;
    check("t43_stale", 32'(dut.stale_q), 32'd0);
    check("t43_state", 32'(dut.state_q), 32'(FETCH));
    check("t43_req_valid", mem_req_valid, 1'b1);
    check("t43_req_addr", mem_req_addr, 32'h200);
    check("t43_inst_valid", inst_valid, 1'b0);

    // fetch_pc wraps modulo 2^32.
    do_reset();
    lat_min = 1; lat_max = 1;
    mem_req_ready = 1'b1; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    #1;
    check("wrap_addr0", mem_req_addr, 32'hFFFF_FFF8);
    cycle();
    check("wrap_addr1", mem_req_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_addr2", mem_req_addr, 32'h0000_0000);
    repeat (3) cycle();
    check("wrap_pop_seen", pop_pc_log.size() >= 2, 1'b1);
    if (pop_pc_log.size() >= 2) begin
      check("wrap_pop0", pop_pc_log[0], 32'hFFFF_FFF8);
      check("wrap_pop1", pop_pc_log[1], 32'hFFFF_FFFC);
    end

    // Reset in the middle of DRAIN.
    do_reset();
    setup_drain(32'h300);
    check("t45_in_drain", 32'(dut.state_q), 32'(DRAIN));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("t45_addr", mem_req_addr, RESET_PC);
    check("t45_inst_valid", inst_valid, 1'b0);
    check("t45_stale", 32'(dut.stale_q), 32'd0);
    check("t45_state", 32'(dut.state_q), 32'(FETCH));

    // Random ready/latency, 1000 instructions against the memory model.
    do_reset();
    lat_min = 1; lat_max = 5;
    exp_pc = RESET_PC;
    n = 0;
    while (n < 1000 && cyc < 40000) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready    = ($urandom_range(0, 3) != 0);
      cycle();
      check("t44_credit",
            (int'(dut.u_queue.count) + int'(dut.outstanding_q)) <= DEPTH, 1'b1);
      while (pop_pc_log.size() > 0) begin
        check("t44_pop_pc", pop_pc_log[0], exp_pc);
        check("t44_pop_inst", pop_inst_log[0], mem_word(exp_pc));
        void'(pop_pc_log.pop_front());
        void'(pop_inst_log.pop_front());
        exp_pc = exp_pc + 32'd4;
        n++;
      end
    end
    check("t44_done", n >= 1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

endmodule
